// File: rtl/sad_tree_min_if.sv
// Port bundle between the PE-array difference stream and the SAD tree / minimum tracker.
// Handshake: abs_valid qualifies abs_outs for exactly one cycle; there is no ready, the block accepts every beat.
interface sad_tree_min_if #(
    parameter int PIXEL    = 8,
    parameter int X        = 32,
    parameter int Y        = 32,
    parameter int NUM_CAND = 64
);
    localparam int N     = X * Y;
    localparam int SAD_W = PIXEL + $clog2(N);
    localparam int CW    = $clog2(NUM_CAND);

    logic               start;
    logic               abs_valid;
    logic [N*PIXEL-1:0] abs_outs;
    logic               busy;
    logic               sad_valid;
    logic [SAD_W-1:0]   sad_out;
    logic               best_valid;
    logic [SAD_W-1:0]   best_sad;
    logic [CW-1:0]      best_idx;
    logic [1:0]         state_dbg;

    modport master (
        output start, abs_valid, abs_outs,
        input  busy, sad_valid, sad_out, best_valid, best_sad, best_idx, state_dbg
    );

    modport slave (
        input  start, abs_valid, abs_outs,
        output busy, sad_valid, sad_out, best_valid, best_sad, best_idx, state_dbg
    );
endinterface

// File: rtl/sad_tree_min.sv
// Three-stage adder tree turning one beat of absolute differences into a SAD, plus a
// search tracker that keeps the smallest SAD and its arrival index over NUM_CAND candidates.
module sad_tree_min #(
    parameter int PIXEL    = 8,
    parameter int X        = 32,
    parameter int Y        = 32,
    parameter int NUM_CAND = 64
) (
    input  logic          clk,
    input  logic          rst,
    sad_tree_min_if.slave io
);
    localparam int N     = X * Y;
    localparam int S1N   = N / 8;
    localparam int S2N   = N / 64;
    localparam int S1W   = PIXEL + 3;
    localparam int S2W   = PIXEL + 6;
    localparam int SAD_W = PIXEL + $clog2(N);
    localparam int CW    = $clog2(NUM_CAND);
    localparam int IW    = $clog2(NUM_CAND + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_n;

    logic [S1W-1:0]   s1_d [S1N];
    logic [S1W-1:0]   s1_q [S1N];
    logic [S2W-1:0]   s2_d [S2N];
    logic [S2W-1:0]   s2_q [S2N];
    logic [SAD_W-1:0] s3_d;
    logic [SAD_W-1:0] s3_q;
    logic             v1, v2, v3;
    logic             t1, t2, t3;

    logic [IW-1:0]    issue_cnt;
    logic [CW-1:0]    retire_cnt;
    logic [SAD_W-1:0] best_sad;
    logic [CW-1:0]    best_idx;
    logic             start_acc;
    logic             track_in;
    logic             retire;

    // Each stage widens by exactly the bits its fan-in needs, so no sum can overflow.
    always_comb begin
        for (int i = 0; i < S1N; i++) begin
            s1_d[i] = '0;
            for (int j = 0; j < 8; j++) begin
                s1_d[i] = s1_d[i] + S1W'(io.abs_outs[(i*8+j)*PIXEL +: PIXEL]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < S2N; i++) begin
            s2_d[i] = '0;
            for (int j = 0; j < 8; j++) begin
                s2_d[i] = s2_d[i] + S2W'(s1_q[i*8+j]);
            end
        end
    end

    always_comb begin
        s3_d = '0;
        for (int i = 0; i < S2N; i++) begin
            s3_d = s3_d + SAD_W'(s2_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            t1   <= 1'b0;
            t2   <= 1'b0;
            t3   <= 1'b0;
            s3_q <= '0;
        end else begin
            v1   <= io.abs_valid;
            t1   <= track_in;
            v2   <= v1;
            t2   <= t1;
            v3   <= v2;
            t3   <= t2;
            s3_q <= s3_d;
        end
    end

    // A beat is tracked only if it enters while a search is open and the candidate quota is not spent.
    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        track_in  = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                start_acc = io.start;
                track_in  = io.abs_valid && io.start;
                if (io.start) state_n = SEARCH;
            end
            SEARCH: begin
                track_in = io.abs_valid && (issue_cnt < IW'(NUM_CAND));
                retire   = v3 && t3;
                if (retire && (retire_cnt == CW'(NUM_CAND - 1))) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt  <= '0;
            retire_cnt <= '0;
            best_sad   <= '0;
            best_idx   <= '0;
        end else if (start_acc) begin
            issue_cnt  <= IW'(io.abs_valid);
            retire_cnt <= '0;
            best_sad   <= '1;
            best_idx   <= '0;
        end else begin
            if (track_in) issue_cnt <= issue_cnt + 1'b1;
            if (retire) begin
                // Strict less-than: on a tie the earlier candidate keeps the win.
                if (s3_q < best_sad) begin
                    best_sad <= s3_q;
                    best_idx <= retire_cnt;
                end
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

    assign io.busy       = (state != IDLE);
    assign io.best_valid = (state == DONE);
    assign io.sad_valid  = v3;
    assign io.sad_out    = s3_q;
    assign io.best_sad   = best_sad;
    assign io.best_idx   = best_idx;
    assign io.state_dbg  = state;
endmodule
